// File: rtl/lv1_bus_req_initiator.sv
// Initiator side of the L1 snoop bus: arbitrates, issues BusRd/BusRdX/Invalidate
// for one L1 miss or upgrade, and returns fill data plus the new MESI state.
module lv1_bus_req_initiator #(
  parameter int unsigned ADDR_WID = 32,
  parameter int unsigned DATA_WID = 32,
  parameter int unsigned MESI_WID = 2,
  parameter logic [MESI_WID-1:0] INVALID   = 0,
  parameter logic [MESI_WID-1:0] SHARED    = 1,
  parameter logic [MESI_WID-1:0] EXCLUSIVE = 2,
  parameter logic [MESI_WID-1:0] MODIFIED  = 3
) (
  input  logic                clk,
  input  logic                rst_b,
  input  logic                miss_valid,
  input  logic [1:0]          miss_type,
  input  logic [ADDR_WID-1:0] miss_addr,
  output logic                miss_ready,
  output logic                bus_req,
  input  logic                bus_gnt,
  output logic                bus_rd,
  output logic                bus_rdx,
  output logic                invalidate,
  output logic [ADDR_WID-1:0] addr_bus,
  input  logic                data_in_bus,
  input  logic [DATA_WID-1:0] data_bus,
  input  logic                shared,
  input  logic                all_inv_done,
  output logic                fill_valid,
  output logic [DATA_WID-1:0] fill_data,
  output logic [MESI_WID-1:0] fill_mesi,
  output logic [1:0]          dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_CMD  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  localparam logic [1:0] T_READ    = 2'd0;
  localparam logic [1:0] T_WRITE   = 2'd1;
  localparam logic [1:0] T_UPGRADE = 2'd2;
  localparam logic [1:0] T_RSVD    = 2'd3;

  state_e                state_q, state_d;
  logic [1:0]            type_q;
  logic [ADDR_WID-1:0]   addr_q;
  logic [DATA_WID-1:0]   fill_data_q;
  logic [MESI_WID-1:0]   fill_mesi_q;
  logic                  accept;
  logic                  complete;

  // miss_valid/miss_ready: a request is taken on a rising edge where both are
  // high; miss_ready is high only in IDLE, and reserved type 3 is never taken.
  assign accept = (state_q == S_IDLE) && miss_valid && (miss_type != T_RSVD);

  // Each command listens only to its own completion strobe.
  assign complete = (state_q == S_CMD) &&
                    ((type_q == T_UPGRADE) ? all_inv_done : data_in_bus);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = S_REQ;
      S_REQ:  if (bus_gnt) state_d = S_CMD;
      S_CMD: begin
        // Completion in the same cycle the grant drops still finishes.
        if (complete)      state_d = S_DONE;
        else if (!bus_gnt) state_d = S_REQ;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    miss_ready = 1'b0;
    bus_req    = 1'b0;
    bus_rd     = 1'b0;
    bus_rdx    = 1'b0;
    invalidate = 1'b0;
    addr_bus   = '0;
    fill_valid = 1'b0;
    case (state_q)
      S_IDLE: miss_ready = 1'b1;
      S_REQ:  bus_req    = 1'b1;
      S_CMD: begin
        bus_req    = 1'b1;
        addr_bus   = addr_q;
        bus_rd     = (type_q == T_READ);
        bus_rdx    = (type_q == T_WRITE);
        invalidate = (type_q == T_UPGRADE);
      end
      S_DONE:  fill_valid = 1'b1;
      default: miss_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      type_q <= T_READ;
      addr_q <= '0;
    end else if (accept) begin
      type_q <= miss_type;
      addr_q <= miss_addr;
    end
  end

  // Fill results are written only on completion, so they hold until the next one.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      fill_data_q <= '0;
      fill_mesi_q <= INVALID;
    end else if (complete) begin
      case (type_q)
        T_READ: begin
          fill_data_q <= data_bus;
          fill_mesi_q <= shared ? SHARED : EXCLUSIVE;
        end
        T_WRITE: begin
          fill_data_q <= data_bus;
          fill_mesi_q <= MODIFIED;
        end
        default: begin
          fill_data_q <= '0;
          fill_mesi_q <= MODIFIED;
        end
      endcase
    end
  end

  assign fill_data = fill_data_q;
  assign fill_mesi = fill_mesi_q;
  assign dbg_state = state_q;

endmodule

// File: doc/lv1_bus_req_initiator.md
# lv1_bus_req_initiator

Initiator side of the L1 snoop-bus protocol. On a processor-side L1 miss or write-on-Shared upgrade, this block:
- arbitrates for the shared L1/L2 bus;
- drives exactly one of `bus_rd`, `bus_rdx` or `invalidate` together with the block address;
- waits for the responding cache or L2 to complete;
- returns fill data and the new MESI state to the L1 controller.

It is the counterpart of the snoop-side hit detection that every other L1 performs on these same command lines.

## Interface

Parameters:
- `ADDR_WID`, 32, block address width
- `DATA_WID`, 32, fill data width
- `MESI_WID`, 2, MESI state width
- `INVALID` / `SHARED` / `EXCLUSIVE` / `MODIFIED`, 0 / 1 / 2 / 3, state encodings

Ports:
- `clk`  in  1  clock; all state changes on rising edge
- `rst_b`  in  1  reset, asynchronous, active-low
- `miss_valid`  in  1  L1 controller presents a request
- `miss_type`  in  2  request type: 0 = read miss, 1 = write miss, 2 = upgrade (write hit on S), 3 = reserved
- `miss_addr`  in  `ADDR_WID`  block address
- `miss_ready`  out  1  block can accept a request
- `bus_req`  out  1  bus arbitration request
- `bus_gnt`  in  1  bus grant from arbiter
- `bus_rd`, `bus_rdx`, `invalidate`  out  1 each  bus commands; one-hot or all zero
- `addr_bus`  out  `ADDR_WID`  command address; 0 when no command is driven
- `data_in_bus`  in  1  responder: read data valid, one-cycle pulse
- `data_bus`  in  `DATA_WID`  responder data
- `shared`  in  1  another L1 holds the block; sampled with `data_in_bus`
- `all_inv_done`  in  1  all snoopers finished invalidating
- `fill_valid`  out  1  one-cycle completion pulse
- `fill_data`  out  `DATA_WID`  data captured from `data_bus`
- `fill_mesi`  out  `MESI_WID`  new state for the line

## Operation

States: IDLE, REQ, CMD, DONE.
- **IDLE**
  - `miss_ready` = 1.
  - `miss_valid` with `miss_type` in {0, 1, 2}: latch type and address, go to REQ.
  - Type 3 is ignored: the block stays in IDLE and `miss_ready` stays 1.
- **REQ**
  - `bus_req` = 1; all commands 0.
  - `bus_gnt` = 1: go to CMD.
- **CMD**
  - `bus_req` = 1; `addr_bus` = latched address.
  - Command driven: type 0 → `bus_rd`, type 1 → `bus_rdx`, type 2 → `invalidate`. It is held every cycle in CMD.
  - Completion for types 0/1 is `data_in_bus` = 1. On that cycle capture `data_bus`, and for type 0 also capture `shared`.
  - Completion for type 2 is `all_inv_done` = 1.
  - On completion go to DONE.
- **DONE**
  - `fill_valid` = 1; `bus_req` and all commands = 0.
  - Always go to IDLE next cycle.
- **Fill state**
  - Type 0: `fill_mesi` = SHARED if the captured `shared` = 1, else EXCLUSIVE.
  - Types 1 and 2: `fill_mesi` = MODIFIED.
- **Fill data**
  - Type 2 carries no data, so `fill_data` = 0.
  - `fill_data` and `fill_mesi` hold their values until the next DONE; they are valid only while `fill_valid` = 1.

## Timing

- **Reset:** while `rst_b` = 0, state = IDLE and every output is 0, except `miss_ready`, which is 1. Reset mid-transaction drops the command immediately and does not assert `fill_valid`.
- **Minimum latency** (grant and completion both immediate): miss accepted in cycle 0 → REQ in cycle 1 → CMD in cycle 2 → completion sampled in cycle 2 → `fill_valid` in cycle 3.
- **Grant loss:** if `bus_gnt` drops in CMD without completion in the same cycle, go back to REQ.
  - Commands deassert in the next cycle.
  - The command is re-issued on a new grant.
  - Completion sampled in the same cycle as grant loss wins: go to DONE.
- **Ignored inputs:**
  - `data_in_bus` or `all_inv_done` outside CMD.
  - `all_inv_done` during type 0/1.
  - `data_in_bus` during type 2.
  - `miss_valid` outside IDLE (`miss_ready` = 0 there).
- **Command encoding:** at most one of `bus_rd` / `bus_rdx` / `invalidate` is ever 1, and only in CMD.
- **Registered outputs:** all outputs are decoded from registered state and latches; none is combinational from bus inputs.

## Test plan

- **Read miss, exclusive:** type 0, addr 0x0000_1A40, grant 2 cycles later, `data_in_bus` 3 cycles into CMD with `data_bus` = 0xDEAD_BEEF and `shared` = 0.
  - Required: `bus_rd` high for exactly 3 cycles, `addr_bus` = 0x1A40, then `fill_valid` for 1 cycle with data 0xDEADBEEF and `fill_mesi` = 2.
- **Read miss, shared:** same as above with `shared` = 1.
  - Required: `fill_mesi` = 1.
- **Write miss:** type 1, immediate grant and data.
  - Required: `bus_rdx` for 1 cycle, `fill_valid` 3 cycles after acceptance, `fill_mesi` = 3.
- **Upgrade:** type 2; `data_in_bus` pulsed in CMD, then `all_inv_done` 4 cycles later.
  - Required: the data pulse is ignored, `invalidate` stays held, then `fill_mesi` = 3 and `fill_data` = 0.
- **Grant loss:** `bus_gnt` dropped in CMD cycle 2, regranted 2 cycles later, then data arrives.
  - Required: commands at 0 during the gap, `bus_rd` re-driven, a single `fill_valid` pulse.
- **Reset mid-CMD and reserved type:**
  - `rst_b` low mid-CMD → all outputs 0, `miss_ready` = 1, no `fill_valid`.
  - Type 3 request → no `bus_req`.
